// File: rtl/fb_pkg.sv
// Shared constants and types for the rectangle fill engine and its
// frame-buffer write interface.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 180;
  localparam int unsigned FB_X_W    = $clog2(FB_WIDTH);
  localparam int unsigned FB_Y_W    = $clog2(FB_HEIGHT);
  localparam int unsigned FB_ADDR_W = $clog2(FB_WIDTH * FB_HEIGHT);

  typedef logic [FB_X_W-1:0]    x_t;
  typedef logic [FB_Y_W-1:0]    y_t;
  typedef logic [FB_X_W:0]      xs_t;
  typedef logic [FB_Y_W:0]      ys_t;
  typedef logic [FB_ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic {
    FB_OP_FILL = 1'b0,
    FB_OP_SWAP = 1'b1
  } fb_op_e;

  typedef struct packed {
    fb_op_e  op;
    x_t      x;
    y_t      y;
    x_t      w;
    y_t      h;
    rgb565_t color;
  } fb_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_SWAP
  } fill_state_e;

endpackage

// File: rtl/fb_rect_clip.sv
// Clips a requested rectangle to the write space: exclusive end column/row
// and a flag for rectangles that cover no pixels at all.
module fb_rect_clip
  import fb_pkg::*;
(
  input  logic [FB_X_W-1:0] x,
  input  logic [FB_Y_W-1:0] y,
  input  logic [FB_X_W-1:0] w,
  input  logic [FB_Y_W-1:0] h,
  output logic [FB_X_W-1:0] x_end,
  output logic [FB_Y_W-1:0] y_end,
  output logic              empty
);

  localparam xs_t X_LIM = xs_t'(FB_WIDTH);
  localparam ys_t Y_LIM = ys_t'(FB_HEIGHT);

  xs_t x_sum;
  ys_t y_sum;

  // Sums carry one extra bit so large origins plus extents never wrap.
  always_comb begin
    x_sum = xs_t'(x) + xs_t'(w);
    y_sum = ys_t'(y) + ys_t'(h);
    x_end = (x_sum > X_LIM) ? x_t'(FB_WIDTH)  : x_sum[FB_X_W-1:0];
    y_end = (y_sum > Y_LIM) ? y_t'(FB_HEIGHT) : y_sum[FB_Y_W-1:0];
    empty = (w == '0) || (h == '0) || (xs_t'(x) >= X_LIM) || (ys_t'(y) >= Y_LIM);
  end

endmodule

// File: rtl/fb_rect_filler.sv
// Command-driven rectangle fill engine: streams clipped RGB565 pixel writes in
// raster order into the frame buffer and issues single-cycle buffer swaps.
module fb_rect_filler
  import fb_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [FB_X_W-1:0]    cmd_x,
  input  logic [FB_Y_W-1:0]    cmd_y,
  input  logic [FB_X_W-1:0]    cmd_w,
  input  logic [FB_Y_W-1:0]    cmd_h,
  input  logic [15:0]          cmd_color,
  output logic [15:0]          write_data,
  output logic [FB_ADDR_W-1:0] write_addr,
  output logic                 write_enable,
  output logic                 swap_buffer,
  output logic                 busy
);

  fb_cmd_t     cmd;
  fill_state_e state;
  x_t          clip_x_end;
  y_t          clip_y_end;
  logic        clip_empty;
  addr_t       row0;

  x_t    x_first;
  x_t    x_last;
  y_t    y_last;
  x_t    cur_x;
  y_t    cur_y;
  addr_t row_base;

  always_comb begin
    cmd = '{op: fb_op_e'(cmd_op), x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h,
            color: rgb565_t'(cmd_color)};
    // One constant multiply per command; per-pixel addresses are incremental.
    row0 = addr_t'(cmd.y) * addr_t'(FB_WIDTH);
  end

  fb_rect_clip u_clip (
    .x     (cmd.x),
    .y     (cmd.y),
    .w     (cmd.w),
    .h     (cmd.h),
    .x_end (clip_x_end),
    .y_end (clip_y_end),
    .empty (clip_empty)
  );

  // cmd_ready is registered so it stays low while reset is held and rises on
  // the first edge after release; otherwise it tracks state == ST_IDLE.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ST_IDLE;
      cmd_ready    <= 1'b0;
      write_data   <= '0;
      write_addr   <= '0;
      write_enable <= 1'b0;
      swap_buffer  <= 1'b0;
      busy         <= 1'b0;
      x_first      <= '0;
      x_last       <= '0;
      y_last       <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
      row_base     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            if (cmd.op == FB_OP_SWAP) begin
              state       <= ST_SWAP;
              swap_buffer <= 1'b1;
            end else begin
              // An empty fill still spends one cycle in ST_FILL with no strobe.
              state        <= ST_FILL;
              write_enable <= !clip_empty;
              if (!clip_empty) begin
                write_data <= cmd.color;
                write_addr <= row0 + addr_t'(cmd.x);
                row_base   <= row0;
                cur_x      <= cmd.x;
                cur_y      <= cmd.y;
                x_first    <= cmd.x;
                x_last     <= clip_x_end - x_t'(1);
                y_last     <= clip_y_end - y_t'(1);
              end
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_FILL: begin
          if (!write_enable || (cur_x == x_last && cur_y == y_last)) begin
            state        <= ST_IDLE;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            cmd_ready    <= 1'b1;
          end else if (cur_x == x_last) begin
            cur_x      <= x_first;
            cur_y      <= cur_y + y_t'(1);
            row_base   <= row_base + addr_t'(FB_WIDTH);
            write_addr <= row_base + addr_t'(FB_WIDTH) + addr_t'(x_first);
          end else begin
            cur_x      <= cur_x + x_t'(1);
            write_addr <= write_addr + addr_t'(1);
          end
        end
        ST_SWAP: begin
          state       <= ST_IDLE;
          swap_buffer <= 1'b0;
          busy        <= 1'b0;
          cmd_ready   <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fb_rect_filler.md
Name: fb_rect_filler

Overview:
- Command-driven rectangle fill engine directly upstream of the double-buffered frame buffer; drives that buffer's write-side signals (write data, write address, write enable, buffer swap).
- Accepts fill and swap commands over a valid/ready handshake.
- For a fill, clips the rectangle to the 320x180 write space and emits one RGB565 pixel write per cycle in raster order.
- For a swap, emits a single-cycle buffer-swap pulse.

Parameters:
- FB_WIDTH, 320, write-space width in pixels
- FB_HEIGHT, 180, write-space height in pixels
- X_W, $clog2(FB_WIDTH) = 9, x/width field width
- Y_W, $clog2(FB_HEIGHT) = 8, y/height field width
- ADDR_W, $clog2(FB_WIDTH*FB_HEIGHT) = 16, write address width

Ports:
- clk_in  input  1  system clock; also drives the frame buffer write clock
- rst_n_in  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  engine can accept a command
- cmd_op  input  1  0 = FILL, 1 = SWAP
- cmd_x  input  X_W  rectangle left column
- cmd_y  input  Y_W  rectangle top row
- cmd_w  input  X_W  rectangle width in pixels
- cmd_h  input  Y_W  rectangle height in pixels
- cmd_color  input  16  RGB565 fill colour
- write_data  output  16  pixel value to frame buffer
- write_addr  output  ADDR_W  pixel address (y*FB_WIDTH + x)
- write_enable  output  1  single-cycle write strobe per pixel
- swap_buffer  output  1  single-cycle swap pulse
- busy  output  1  high while a command is executing

Behaviour:
- Reset is asynchronous on the falling edge of rst_n_in. State returns to IDLE. write_data, write_addr, write_enable, swap_buffer and busy all go to 0; cmd_ready goes to 1 once reset is released.
- Reset asserted mid-fill aborts the fill. No further writes occur and no swap is generated.
- States are IDLE, FILL and SWAP. cmd_ready = (state == IDLE). A handshake occurs when cmd_valid && cmd_ready on a rising edge, and all cmd_* fields are registered at that edge.
- Clipping, computed at accept:
  - x_end = min(cmd_x + cmd_w, FB_WIDTH) and y_end = min(cmd_y + cmd_h, FB_HEIGHT).
  - Sums are computed at X_W+1 and Y_W+1 bits, with no wrap.
  - A command is empty if cmd_w == 0, cmd_h == 0, cmd_x >= FB_WIDTH, or cmd_y >= FB_HEIGHT.
- FILL:
  - A non-empty fill accepted at edge N enters FILL. The first write_enable is high in the cycle after edge N, with write_addr = cmd_y*FB_WIDTH + cmd_x.
  - Each following cycle advances x. At x == x_end-1 the engine wraps to cmd_x, increments y, and advances the row base by FB_WIDTH.
  - Addresses are formed incrementally (row-base accumulator plus column). No per-pixel multiplier.
  - Exactly (x_end-cmd_x)*(y_end-cmd_y) consecutive write_enable cycles are produced, with no bubbles.
  - After the last pixel the engine returns to IDLE; cmd_ready is high in the cycle after the last write.
- An empty FILL command produces no writes; the engine holds busy for one cycle, then returns to IDLE.
- SWAP: accepted at edge N, swap_buffer is high for exactly the one cycle after N, then the engine returns to IDLE. Writes issued after the swap target the new buffer, because the frame buffer shares the same clock.
- write_data and write_addr hold their last values when write_enable is low; consumers qualify them on write_enable.
- busy = (state != IDLE). It is high from the cycle after accept until the final write or swap cycle, inclusive.
- Ordering: commands execute strictly in acceptance order. A SWAP is never issued while a fill is still writing.
- cmd_valid while busy is ignored, and the command is held by the producer.

Decomposition:
- Package fb_pkg holds:
  - FB_WIDTH, FB_HEIGHT, FB_ADDR_W constants
  - rgb565_t typedef (16-bit packed r[4:0], g[5:0], b[4:0])
  - fb_op_e enum (FB_OP_FILL, FB_OP_SWAP)
  - fb_cmd_t packed struct (op, x, y, w, h, color)
  - fill_state_e enum
- One combinational sub-module, fb_rect_clip, computes x_end, y_end and the empty flag. The sequencing FSM and address counters stay in fb_rect_filler.

Test Plan:
- FILL (x=10, y=5, w=2, h=2, color 0xF800) -> four consecutive write_enable cycles with addrs 1610, 1611, 1930, 1931, write_data = 0xF800, first write one cycle after accept; cmd_ready high the cycle after addr 1931.
- Corner clip FILL (x=318, y=179, w=5, h=3) -> exactly two writes, addrs 57598 and 57599, then idle.
- Empty commands (w=0; x=320; y=200) -> zero write_enable pulses; busy high for one cycle each; cmd_ready high again by the second cycle after accept.
- FILL 1x1 at (0,0), then SWAP back-to-back with cmd_valid held -> write at addr 0, then swap_buffer high for exactly one cycle afterwards, never overlapping a write.
- Full-screen FILL (0, 0, 320, 180) -> 57600 contiguous writes, addrs 0..57599 in order, no gaps.
- rst_n_in low after the 5th write of a 4x4 fill -> all outputs 0 immediately (asynchronously); after release, no residual writes, and cmd_ready = 1.
